// File: rtl/ads1292_spi_responder.sv
// rtl/ads1292_spi_responder.sv - ADS1292-side SPI responder (mode 1) with command decoder, register file and DRDY/frame model
// All SPI pins are oversampled in i_CLK; i_CLK must run at least 8x SCLK.
module ads1292_spi_responder #(
  parameter logic [7:0] ID_VALUE    = 8'h53,
  parameter int         NUM_REGS    = 12,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic        i_SCLK,
  input  logic        i_CSN,
  input  logic        i_MOSI,
  output logic        o_MISO,
  output logic        o_MISO_OE,
  output logic        o_DRDY,
  input  logic        i_RESET_PIN,
  input  logic        i_START_PIN,
  input  logic        i_SAMPLE_VALID,
  input  logic [23:0] i_CH1,
  input  logic [23:0] i_CH2,
  output logic        o_RUNNING,
  output logic        o_RDATAC,
  output logic        o_OVERRUN
);

  typedef enum logic [2:0] {IDLE, CMD, RREG_N, RREG_DATA, WREG_N, WREG_DATA, DATA_OUT} state_t;

  // Synchronizer lane order {start, reset_n, mosi, csn, sclk}, reset to the pins' idle levels.
  localparam logic [4:0] SYNC_RST = 5'b01010;

  logic [4:0] sync_q [SYNC_STAGES];
  logic       sclk_prev_q, csn_prev_q;
  logic       sclk_s, csn_s, mosi_s, rstpin_s, start_s;
  logic       sclk_rise, sclk_fall, csn_fall, csn_rise;

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
    end else begin
      sync_q[0] <= {i_START_PIN, i_RESET_PIN, i_MOSI, i_CSN, i_SCLK};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  assign {start_s, rstpin_s, mosi_s, csn_s, sclk_s} = sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [71:0] tx_q, tx_d;
  logic        miso_q, miso_d;
  logic [4:0]  addr_q, addr_d, addr_inc;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];
  logic        rdatac_q, rdatac_d;
  logic        run_q, run_d;
  logic        drdy_q, drdy_d;
  logic        first_q, first_d;
  logic        latch_q, latch_d;
  logic        overrun_q, overrun_d;
  logic [47:0] frame_q, frame_d;
  logic [71:0] frame_word;
  logic [7:0]  rx_byte, rd_cur, rd_next;
  logic        byte_done, cmd_reset;

  assign frame_word = {4'hC, 20'h0, frame_q};
  // Address counter saturates at 0x1F rather than wrapping to 0x00.
  assign addr_inc   = (addr_q == 5'h1F) ? addr_q : addr_q + 5'd1;

  always_comb begin
    rd_cur  = 8'h00;
    rd_next = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == 5'(i))   rd_cur  = regs_q[i];
      if (addr_inc == 5'(i)) rd_next = regs_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    regs_d    = regs_q;
    rdatac_d  = rdatac_q;
    run_d     = run_q;
    drdy_d    = drdy_q;
    first_d   = first_q;
    frame_d   = frame_q;
    latch_d   = 1'b0;
    overrun_d = 1'b0;
    rx_byte   = {rx_q[6:0], mosi_s};
    byte_done = 1'b0;
    cmd_reset = 1'b0;

    if (csn_fall) begin
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
      if (rdatac_q && !drdy_q) begin
        tx_d    = frame_word;
        state_d = DATA_OUT;
        first_d = 1'b1;
      end else begin
        tx_d    = '0;
        state_d = CMD;
      end
    end else if (csn_rise) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
      first_d   = 1'b0;
    end else if (state_q != IDLE) begin
      if (sclk_rise) begin
        miso_d = tx_q[71];
        tx_d   = {tx_q[70:0], 1'b0};
      end
      if (sclk_fall) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        byte_done = (bit_cnt_q == 3'd7);
        if (first_q) begin
          drdy_d  = 1'b1;
          first_d = 1'b0;
        end
      end
    end

    if (byte_done) begin
      case (state_q)
        CMD: begin
          if (rx_byte == 8'h06)      cmd_reset = 1'b1;
          else if (rx_byte == 8'h08) run_d = 1'b1;
          else if (rx_byte == 8'h0A) run_d = 1'b0;
          else if (rx_byte == 8'h11) rdatac_d = 1'b0;
          else if (rx_byte == 8'h10) rdatac_d = 1'b1;
          else if (!rdatac_q) begin
            if (rx_byte == 8'h12) begin
              tx_d    = frame_word;
              state_d = DATA_OUT;
              first_d = 1'b1;
            end else if (rx_byte[7:5] == 3'b001) begin
              addr_d  = rx_byte[4:0];
              state_d = RREG_N;
            end else if (rx_byte[7:5] == 3'b010) begin
              addr_d  = rx_byte[4:0];
              state_d = WREG_N;
            end
          end
        end
        RREG_N: begin
          cnt_d   = rx_byte;
          tx_d    = {rd_cur, 64'h0};
          state_d = RREG_DATA;
        end
        RREG_DATA: begin
          if (cnt_q == 8'd0) begin
            state_d = CMD;
          end else begin
            addr_d = addr_inc;
            cnt_d  = cnt_q - 8'd1;
            tx_d   = {rd_next, 64'h0};
          end
        end
        WREG_N: begin
          cnt_d   = rx_byte;
          state_d = WREG_DATA;
        end
        WREG_DATA: begin
          for (int i = 1; i < NUM_REGS; i++) begin
            if (addr_q == 5'(i)) regs_d[i] = rx_byte;
          end
          if (cnt_q == 8'd0) begin
            state_d = CMD;
          end else begin
            addr_d = addr_inc;
            cnt_d  = cnt_q - 8'd1;
          end
        end
        DATA_OUT: if (rx_byte == 8'h11) rdatac_d = 1'b0;
        default: ;
      endcase
    end

    if (cmd_reset) begin
      regs_d[0] = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) regs_d[i] = 8'h00;
      rdatac_d = 1'b1;
      run_d    = 1'b0;
      drdy_d   = 1'b1;
    end

    // A fresh sample outranks a readout clearing DRDY in the same cycle.
    if (i_SAMPLE_VALID && o_RUNNING) begin
      frame_d   = {i_CH1, i_CH2};
      latch_d   = 1'b1;
      overrun_d = ~drdy_q;
    end
    if (latch_q) drdy_d = 1'b0;

    if (!rstpin_s) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      rx_d      = 8'h00;
      tx_d      = '0;
      miso_d    = 1'b0;
      addr_d    = 5'd0;
      cnt_d     = 8'd0;
      regs_d[0] = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) regs_d[i] = 8'h00;
      rdatac_d  = 1'b1;
      run_d     = 1'b0;
      drdy_d    = 1'b1;
      first_d   = 1'b0;
      latch_d   = 1'b0;
      overrun_d = 1'b0;
      frame_d   = '0;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      rx_q      <= 8'h00;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      addr_q    <= 5'd0;
      cnt_q     <= 8'd0;
      regs_q[0] <= ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
      rdatac_q  <= 1'b1;
      run_q     <= 1'b0;
      drdy_q    <= 1'b1;
      first_q   <= 1'b0;
      latch_q   <= 1'b0;
      overrun_q <= 1'b0;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      regs_q    <= regs_d;
      rdatac_q  <= rdatac_d;
      run_q     <= run_d;
      drdy_q    <= drdy_d;
      first_q   <= first_d;
      latch_q   <= latch_d;
      overrun_q <= overrun_d;
      frame_q   <= frame_d;
    end
  end

  assign o_MISO    = miso_q;
  assign o_MISO_OE = ~csn_s & rstpin_s;
  assign o_DRDY    = drdy_q;
  assign o_RUNNING = start_s | run_q;
  assign o_RDATAC  = rdatac_q;
  assign o_OVERRUN = overrun_q;

endmodule

// File: tb/tb_ads1292_spi_responder.sv
// tb/tb_ads1292_spi_responder.sv - scoreboard bench for ads1292_spi_responder
module tb_ads1292_spi_responder;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        sclk = 1'b0, csn = 1'b1, mosi = 1'b0;
  logic        reset_pin = 1'b1, start_pin = 1'b0, sv = 1'b0;
  logic [23:0] ch1 = '0, ch2 = '0;
  logic        miso, miso_oe, drdy, running, rdatac, overrun;

  int          n_cmp = 0, n_err = 0, ovr_cnt = 0, mon_n = 0, byte_no = 0;
  logic [7:0]  mon_sh = 8'h00;

  typedef struct {
    logic       care;
    logic [7:0] val;
    int         tag;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  ads1292_spi_responder dut (
    .i_CLK(clk), .i_RSTN(rstn), .i_SCLK(sclk), .i_CSN(csn), .i_MOSI(mosi),
    .o_MISO(miso), .o_MISO_OE(miso_oe), .o_DRDY(drdy),
    .i_RESET_PIN(reset_pin), .i_START_PIN(start_pin), .i_SAMPLE_VALID(sv),
    .i_CH1(ch1), .i_CH2(ch2),
    .o_RUNNING(running), .o_RDATAC(rdatac), .o_OVERRUN(overrun)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: assembles each MISO byte at the initiator's sampling edge.
  always @(negedge sclk) begin
    if (!csn) begin
      mon_sh = {mon_sh[6:0], miso};
      mon_n++;
      if (mon_n == 8) begin
        mon_n = 0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL miso_unexpected: got %02h with empty scoreboard", mon_sh);
        end else begin
          e = exp_q.pop_front();
          if (e.care) begin
            n_cmp++;
            if (mon_sh !== e.val) begin
              n_err++;
              $display("FAIL miso_byte#%0d: got %02h want %02h", e.tag, mon_sh, e.val);
            end
          end
        end
      end
    end
  end

  always @(posedge csn) mon_n = 0;

  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic dchk);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      sclk = 1'b1;
      wait_clks(8);
      if (dchk && i == 7) check_bit("drdy_before_first_fall", drdy, 1'b0);
      sclk = 1'b0;
      wait_clks(8);
      if (dchk && i == 7) check_bit("drdy_after_first_fall", drdy, 1'b1);
    end
  endtask

  task automatic xb(input logic [7:0] tx, input logic care = 1'b0,
                    input logic [7:0] exp = 8'h00, input logic dchk = 1'b0);
    exp_t x;
    x.care = care;
    x.val  = exp;
    x.tag  = byte_no;
    byte_no++;
    exp_q.push_back(x);
    spi_bits(tx, 8, dchk);
  endtask

  task automatic csn_low();
    csn = 1'b0;
    wait_clks(8);
  endtask

  task automatic csn_high();
    csn = 1'b1;
    mosi = 1'b0;
    wait_clks(16);
  endtask

  task automatic sample(input logic [23:0] a, input logic [23:0] b);
    ch1 = a;
    ch2 = b;
    sv  = 1'b1;
    wait_clks(1);
    sv  = 1'b0;
  endtask

  task automatic readout(input logic [23:0] a, input logic [23:0] b);
    logic [71:0] f;
    f = {4'hC, 20'h0, a, b};
    csn_low();
    check_bit("miso_oe_csn_low", miso_oe, 1'b1);
    for (int i = 0; i < 9; i++) xb(8'h00, 1'b1, f[71-8*i -: 8], (i == 0));
    csn_high();
  endtask

  initial begin
    wait_clks(3);
    rstn = 1'b1;
    wait_clks(4);
    check_bit("rst_miso", miso, 1'b0);
    check_bit("rst_miso_oe", miso_oe, 1'b0);
    check_bit("rst_drdy", drdy, 1'b1);
    check_bit("rst_running", running, 1'b0);
    check_bit("rst_rdatac", rdatac, 1'b1);
    check_bit("rst_overrun", overrun, 1'b0);

    // RREG is not honored while in continuous-read mode
    csn_low(); xb(8'h20); xb(8'h00); xb(8'h00, 1'b1, 8'h00); csn_high();

    csn_low(); xb(8'h11); xb(8'h20); xb(8'h00); xb(8'h00, 1'b1, 8'h53); csn_high();
    check_bit("sdatac_rdatac", rdatac, 1'b0);
    check_bit("idle_drdy", drdy, 1'b1);

    csn_low(); xb(8'h41); xb(8'h01); xb(8'hA5); xb(8'h3C); csn_high();
    csn_low(); xb(8'h21); xb(8'h01); xb(8'h00, 1'b1, 8'hA5); xb(8'h00, 1'b1, 8'h3C); csn_high();

    csn_low(); xb(8'h40); xb(8'h00); xb(8'hFF); csn_high();
    csn_low(); xb(8'h20); xb(8'h00); xb(8'h00, 1'b1, 8'h53); csn_high();

    // last implemented register, then one past the end
    csn_low(); xb(8'h4B); xb(8'h01); xb(8'h77); xb(8'h88); csn_high();
    csn_low(); xb(8'h2B); xb(8'h01); xb(8'h00, 1'b1, 8'h77); xb(8'h00, 1'b1, 8'h00); csn_high();

    start_pin = 1'b1;
    csn_low(); xb(8'h10); csn_high();
    check_bit("start_pin_running", running, 1'b1);
    check_bit("rdatac_cmd", rdatac, 1'b1);
    sample(24'h123456, 24'hABCDEF);
    wait_clks(3);
    check_bit("drdy_after_sample", drdy, 1'b0);
    readout(24'h123456, 24'hABCDEF);
    check_bit("drdy_after_readout", drdy, 1'b1);

    begin
      int o0;
      o0 = ovr_cnt;
      sample(24'h111111, 24'h222222);
      wait_clks(5);
      sample(24'h654321, 24'h0FEDCB);
      wait_clks(5);
      check_int("overrun_pulses", ovr_cnt - o0, 1);
      check_bit("drdy_overrun", drdy, 1'b0);
    end
    readout(24'h654321, 24'h0FEDCB);

    // aborted partial command byte
    csn_low(); spi_bits(8'h41, 3, 1'b0); csn_high();
    csn_low(); xb(8'h11); xb(8'h21); xb(8'h00); xb(8'h00, 1'b1, 8'hA5); csn_high();

    start_pin = 1'b0;
    wait_clks(4);
    reset_pin = 1'b0;
    wait_clks(4);
    reset_pin = 1'b1;
    wait_clks(6);
    check_bit("pinrst_rdatac", rdatac, 1'b1);
    check_bit("pinrst_running", running, 1'b0);
    check_bit("pinrst_drdy", drdy, 1'b1);
    csn_low(); xb(8'h11); xb(8'h21); xb(8'h00); xb(8'h00, 1'b1, 8'h00); csn_high();

    csn_low(); xb(8'h08); csn_high();
    check_bit("start_cmd_running", running, 1'b1);
    csn_low(); xb(8'h0A); csn_high();
    check_bit("stop_cmd_running", running, 1'b0);

    csn_low();
    xb(8'h41); xb(8'h00); xb(8'h5A); xb(8'h06); xb(8'h11);
    xb(8'h21); xb(8'h00); xb(8'h00, 1'b1, 8'h00);
    csn_high();

    wait_clks(10);
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
